// File: rtl/biriscv_div_pkg.sv
// Shared divider definitions: issue FSM encoding, op bundle, watchdog default
// and the RV32M divide opcode/mask pairs also decoded by the divider.
`timescale 1ns/1ps
package biriscv_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } div_state_e;

    typedef struct packed {
        logic [31:0] opcode;
        logic [31:0] pc;
        logic [31:0] ra_operand;
        logic [31:0] rb_operand;
        logic [4:0]  rd_idx;
        logic [4:0]  ra_idx;
        logic [4:0]  rb_idx;
    } div_op_t;

    localparam int unsigned DIV_TIMEOUT_CYCLES_DEFAULT = 40;

    localparam logic [31:0] INST_DIV       = 32'h02004033;
    localparam logic [31:0] INST_DIV_MASK  = 32'hfe00707f;
    localparam logic [31:0] INST_DIVU      = 32'h02005033;
    localparam logic [31:0] INST_DIVU_MASK = 32'hfe00707f;
    localparam logic [31:0] INST_REM       = 32'h02006033;
    localparam logic [31:0] INST_REM_MASK  = 32'hfe00707f;
    localparam logic [31:0] INST_REMU      = 32'h02007033;
    localparam logic [31:0] INST_REMU_MASK = 32'hfe00707f;

endpackage

// File: rtl/biriscv_div_watchdog.sv
// Response watchdog for the divider issue FSM: counts cycles while enabled,
// restarts on clear, and flags expiry once TIMEOUT_CYCLES have elapsed.
`timescale 1ns/1ps
module biriscv_div_watchdog
    import biriscv_div_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DIV_TIMEOUT_CYCLES_DEFAULT
)
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q, count_d;

    // Saturates at the limit so a stuck enable never wraps into a second expiry.
    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (enable_i && (count_q != LIMIT))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign expire_o = enable_i && (count_q == LIMIT);

endmodule

// File: rtl/biriscv_div_issue.sv
// Issue sequencer for the iterative divider: one op in flight, stall until the
// result returns, flush-kill handling. BIRISCV_DIV_TIMEOUT_EN adds a watchdog.
`timescale 1ns/1ps
module biriscv_div_issue
    import biriscv_div_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DIV_TIMEOUT_CYCLES_DEFAULT
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        div_valid_i,
    output logic        div_ready_o,
    input  logic [31:0] div_opcode_i,
    input  logic [31:0] div_pc_i,
    input  logic [31:0] div_ra_operand_i,
    input  logic [31:0] div_rb_operand_i,
    input  logic [4:0]  div_rd_idx_i,
    input  logic [4:0]  div_ra_idx_i,
    input  logic [4:0]  div_rb_idx_i,
    input  logic        flush_i,
    output logic        opcode_valid_o,
    output logic [31:0] opcode_opcode_o,
    output logic [31:0] opcode_pc_o,
    output logic [31:0] opcode_ra_operand_o,
    output logic [31:0] opcode_rb_operand_o,
    output logic [4:0]  opcode_rd_idx_o,
    output logic [4:0]  opcode_ra_idx_o,
    output logic [4:0]  opcode_rb_idx_o,
    output logic        opcode_invalid_o,
    input  logic        writeback_valid_i,
    input  logic [31:0] writeback_value_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_value_o,
    output logic [31:0] wb_pc_o,
    output logic        stall_o,
    output logic        timeout_o
);

    div_state_e  state_q, state_d;
    div_op_t     op_q, op_d;
    logic        kill_q, kill_d;
    logic [31:0] result_q, result_d;
    logic        timeout;

`ifdef BIRISCV_DIV_TIMEOUT_EN
    logic wd_expire;

    biriscv_div_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q == ST_ISSUE),
        .enable_i (state_q == ST_WAIT),
        .expire_o (wd_expire)
    );

    // A response arriving on the expiry cycle still completes normally.
    assign timeout = wd_expire && !writeback_valid_i;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        kill_d   = kill_q;
        result_d = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (div_valid_i && !flush_i) begin
                    op_d = '{opcode:     div_opcode_i,
                             pc:         div_pc_i,
                             ra_operand: div_ra_operand_i,
                             rb_operand: div_rb_operand_i,
                             rd_idx:     div_rd_idx_i,
                             ra_idx:     div_ra_idx_i,
                             rb_idx:     div_rb_idx_i};
                    kill_d  = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                kill_d  = kill_q | flush_i;
                state_d = ST_WAIT;
            end
            // The divider cannot be aborted: a killed op still waits for its result.
            ST_WAIT: begin
                kill_d = kill_q | flush_i;
                if (writeback_valid_i) begin
                    result_d = writeback_value_i;
                    state_d  = ST_WB;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                kill_d  = kill_q | flush_i;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            kill_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            kill_q   <= kill_d;
            result_q <= result_d;
        end
    end

    assign div_ready_o         = (state_q == ST_IDLE);
    assign stall_o             = (state_q != ST_IDLE) || (div_valid_i && !flush_i);
    assign opcode_valid_o      = (state_q == ST_ISSUE);
    assign opcode_opcode_o     = op_q.opcode;
    assign opcode_pc_o         = op_q.pc;
    assign opcode_ra_operand_o = op_q.ra_operand;
    assign opcode_rb_operand_o = op_q.rb_operand;
    assign opcode_rd_idx_o     = op_q.rd_idx;
    assign opcode_ra_idx_o     = op_q.ra_idx;
    assign opcode_rb_idx_o     = op_q.rb_idx;
    assign opcode_invalid_o    = 1'b0;
    assign wb_valid_o          = (state_q == ST_WB) && !kill_q && !flush_i && (op_q.rd_idx != 5'd0);
    assign wb_rd_idx_o         = op_q.rd_idx;
    assign wb_value_o          = result_q;
    assign wb_pc_o             = op_q.pc;
    assign timeout_o           = timeout;

endmodule
